ofdm_framer: RTL

OFDM_FRAMER -- requirements
Module: ofdm_framer

---
 rtl/ofdm_framer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ofdm_framer.sv
// OFDM framer: short-training preamble, then per symbol a cyclic prefix copied
// from the buffered symbol tail followed by the full symbol body.
module ofdm_framer #(
  parameter int SYMBOL_LEN         = 64,
  parameter int CYCLIC_PREFIX_LEN  = 16,
  parameter int SHORT_SYMBOL_LEN   = 16,
  parameter int SHORT_PREAMBLE_LEN = 160,
  parameter int MAX_NUM_SYMBOLS    = 512
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [31:0]                            i_tdata,
  input  logic                                   i_tlast,
  input  logic                                   i_tvalid,
  output logic                                   i_tready,
  output logic [31:0]                            o_tdata,
  output logic                                   o_tlast,
  output logic                                   o_tvalid,
  input  logic                                   o_tready,
  input  logic [$clog2(MAX_NUM_SYMBOLS+1)-1:0]   num_symbols,
  input  logic                                   num_symbols_valid,
  input  logic [$clog2(SHORT_SYMBOL_LEN)-1:0]    pre_addr,
  input  logic [31:0]                            pre_data,
  input  logic                                   pre_wr,
  output logic                                   sof,
  output logic                                   eof
);

  localparam int NW      = $clog2(MAX_NUM_SYMBOLS + 1);
  localparam int TW      = $clog2(SHORT_SYMBOL_LEN);
  localparam int AW      = $clog2(SYMBOL_LEN);
  localparam int CNT_MAX = (SHORT_PREAMBLE_LEN > SYMBOL_LEN) ? SHORT_PREAMBLE_LEN : SYMBOL_LEN;
  localparam int BW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    FILL,
    CP,
    BODY
  } state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   beat_cnt;
  logic [TW-1:0]   tbl_idx;
  logic [NW-1:0]   sym_cnt;
  logic [NW-1:0]   frame_syms;
  logic [NW-1:0]   num_lat;
  logic [31:0]     pre_table [SHORT_SYMBOL_LEN];
  logic [31:0]     sym_buf   [SYMBOL_LEN];

  logic            pre_last, cp_last, body_last, sym_last, adv;
  logic [AW-1:0]   cp_addr;
  logic            unused_tlast;

  assign unused_tlast = i_tlast;

  assign pre_last  = (beat_cnt == BW'(SHORT_PREAMBLE_LEN - 1));
  assign cp_last   = (beat_cnt == BW'(CYCLIC_PREFIX_LEN - 1));
  assign body_last = (beat_cnt == BW'(SYMBOL_LEN - 1));
  assign sym_last  = (sym_cnt == frame_syms - NW'(1));
  assign cp_addr   = AW'(SYMBOL_LEN - CYCLIC_PREFIX_LEN) + beat_cnt[AW-1:0];
  assign adv       = (o_tvalid && o_tready) || (i_tready && i_tvalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are decoded from state and counters only, so they cannot change
  // while a beat is stalled.
  always_comb begin
    state_nxt = state;
    o_tvalid  = 1'b0;
    i_tready  = 1'b0;
    o_tlast   = 1'b0;
    sof       = 1'b0;
    eof       = 1'b0;
    o_tdata   = '0;
    case (state)
      IDLE: begin
        if (num_lat != '0 && i_tvalid) state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        o_tvalid = 1'b1;
        o_tdata  = pre_table[tbl_idx];
        sof      = (beat_cnt == '0);
        o_tlast  = pre_last;
        if (o_tready && pre_last) state_nxt = FILL;
      end
      FILL: begin
        i_tready = 1'b1;
        if (i_tvalid && body_last) state_nxt = CP;
      end
      CP: begin
        o_tvalid = 1'b1;
        o_tdata  = sym_buf[cp_addr];
        if (o_tready && cp_last) state_nxt = BODY;
      end
      BODY: begin
        o_tvalid = 1'b1;
        o_tdata  = sym_buf[beat_cnt[AW-1:0]];
        o_tlast  = body_last;
        eof      = body_last && sym_last;
        if (o_tready && body_last) state_nxt = sym_last ? IDLE : FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt   <= '0;
      tbl_idx    <= '0;
      sym_cnt    <= '0;
      frame_syms <= '0;
      num_lat    <= '0;
    end else begin
      if (num_symbols_valid)
        num_lat <= (num_symbols > NW'(MAX_NUM_SYMBOLS)) ? NW'(MAX_NUM_SYMBOLS) : num_symbols;

      if (state_nxt != state)
        beat_cnt <= '0;
      else if (adv)
        beat_cnt <= beat_cnt + BW'(1);

      if (state == IDLE)
        tbl_idx <= '0;
      else if (state == PREAMBLE && o_tready)
        tbl_idx <= (tbl_idx == TW'(SHORT_SYMBOL_LEN - 1)) ? '0 : tbl_idx + TW'(1);

      if (state == IDLE)
        sym_cnt <= '0;
      else if (state == BODY && o_tready && body_last)
        sym_cnt <= sym_cnt + NW'(1);

      if (state == IDLE && state_nxt == PREAMBLE)
        frame_syms <= num_lat;
    end
  end

  // Storage is deliberately not reset so the training table survives an abort.
  always_ff @(posedge clk) begin
    if (state == FILL && i_tvalid)
      sym_buf[beat_cnt[AW-1:0]] <= i_tdata;
    if (state == IDLE && pre_wr)
      pre_table[pre_addr] <= pre_data;
  end

endmodule
